// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, PC type and FSM state encoding for the fetch front end.
package fetch_pkg;

    localparam int unsigned PC_W_DEF       = 32;
    localparam int unsigned IMEM_DEPTH_DEF = 128;
    localparam int unsigned RESET_PC_DEF   = 0;

    typedef logic [PC_W_DEF-1:0] pc_t;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: two saturating 32-bit event counters (fetched words, stall cycles).
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Next counts: increment on event, stick at all-ones.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_inc_i && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_inc_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Drives a registered word address into a
// one-cycle-latency instruction memory, tags each returned word with its PC and
// presents it to decode with a valid/stall handshake. Handles redirect/flush and halts
// on fetches beyond IMEM_DEPTH-1 (sticky addr_err_o).
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt_o / perf_stall_cnt_o.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W       = PC_W_DEF,
    parameter int unsigned     IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_pc_o,
    input  logic [31:0]     imem_inst_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            if_valid_o,
    output logic [31:0]     if_inst_o,
    output logic [PC_W-1:0] if_pc_o,
    output logic            addr_err_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_stall_cnt_o
`endif
);

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);
    localparam logic [PC_W-1:0] LAST_PC  = PC_W'(IMEM_DEPTH - 1);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            req_vld_q, req_vld_d;
    // Word that was on imem_inst when a stall began; the memory moves on to pc_q.
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_inst_q, skid_inst_d;
    logic            skid_vld_q, skid_vld_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_inst_q, if_inst_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic            addr_err_q, addr_err_d;

    logic            adv;
    logic            adv_from_skid;
    logic            ld_vld;
    logic [PC_W-1:0] ld_pc;
    logic [31:0]     ld_inst;

    // Next-state: redirect > stall > advance; HALT drains the tagged word then idles.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        req_vld_d     = req_vld_q;
        skid_pc_d     = skid_pc_q;
        skid_inst_d   = skid_inst_q;
        skid_vld_d    = skid_vld_q;
        if_valid_d    = if_valid_q;
        if_inst_d     = if_inst_q;
        if_pc_d       = if_pc_q;
        addr_err_d    = addr_err_q;
        adv           = 1'b0;
        adv_from_skid = 1'b0;
        ld_vld        = 1'b0;
        ld_pc         = req_pc_q;
        ld_inst       = imem_inst_i;

        if ((state_q != START) && redirect_valid_i) begin
            pc_d       = redirect_pc_i;
            req_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            if_valid_d = 1'b0;
            if (redirect_pc_i >= DEPTH_PC) begin
                state_d    = HALT;
                addr_err_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                START: adv = 1'b1;
                RUN: begin
                    if (stall_i && if_valid_q) begin
                        // Park the in-flight word; pc_q holds so the memory keeps
                        // re-reading the following word for the whole stall.
                        state_d     = HOLD;
                        skid_vld_d  = req_vld_q;
                        skid_pc_d   = req_pc_q;
                        skid_inst_d = imem_inst_i;
                        req_pc_d    = pc_q;
                        req_vld_d   = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
                HOLD: begin
                    if (stall_i) begin
                        req_pc_d  = pc_q;
                        req_vld_d = 1'b1;
                    end else begin
                        adv           = 1'b1;
                        adv_from_skid = 1'b1;
                    end
                end
                HALT: begin
                    // imem_pc is out of range here, so the tagged word cannot be
                    // re-read later; it drains regardless of stall.
                    if_valid_d = req_vld_q;
                    if (req_vld_q) begin
                        if_inst_d = imem_inst_i;
                        if_pc_d   = req_pc_q;
                    end
                    req_vld_d = 1'b0;
                end
            endcase

            if (adv) begin
                if (adv_from_skid) begin
                    ld_vld  = skid_vld_q;
                    ld_pc   = skid_pc_q;
                    ld_inst = skid_inst_q;
                end else begin
                    ld_vld = req_vld_q;
                end
                if_valid_d = ld_vld;
                if (ld_vld) begin
                    if_inst_d = ld_inst;
                    if_pc_d   = ld_pc;
                end
                skid_vld_d = 1'b0;
                req_pc_d   = pc_q;
                if (pc_q >= DEPTH_PC) begin
                    // Only reachable with an out-of-range RESET_PC.
                    req_vld_d  = 1'b0;
                    state_d    = HALT;
                    addr_err_d = 1'b1;
                end else begin
                    req_vld_d = 1'b1;
                    pc_d      = pc_q + PC_W'(1);
                    if (pc_q == LAST_PC) begin
                        state_d    = HALT;
                        addr_err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= START;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_vld_q   <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_vld_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_vld_q   <= req_vld_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_vld_q  <= skid_vld_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign imem_pc_o  = pc_q;
    assign if_valid_o = if_valid_q;
    assign if_inst_o  = if_inst_q;
    assign if_pc_o    = if_pc_q;
    assign addr_err_o = addr_err_q;

`ifdef FETCH_PERF_EN
    logic hold_now;
    logic fetch_load;

    // A valid if_* that is merely being held does not count as a fresh fetch.
    assign hold_now   = !redirect_valid_i && stall_i && if_valid_q &&
                        ((state_q == RUN) || (state_q == HOLD));
    assign fetch_load = if_valid_d && !hold_now;

    fetch_perf_ctr u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc_i (fetch_load),
        .stall_inc_i (state_q == HOLD),
        .fetch_cnt_o (perf_fetch_cnt_o),
        .stall_cnt_o (perf_stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit against a stream-level model
// (address counter, one in-flight word, whole pipeline frozen on stall).
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = IMEM_DEPTH_DEF;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    pc_t         imem_pc;
    logic [31:0] imem_inst = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    pc_t         redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    pc_t         if_pc;
    logic        addr_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_pc_o        (imem_pc),
        .imem_inst_i      (imem_inst),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .if_valid_o       (if_valid),
        .if_inst_o        (if_inst),
        .if_pc_o          (if_pc),
        .addr_err_o       (addr_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle registered read, poison outside the array.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        imem_inst <= (imem_pc < DEPTH) ? mem[imem_pc[AW-1:0]] : 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model state.
    int m_nxt;     // next address the fetcher issues (== imem_pc)
    int m_slot;    // address of the word in flight, -1 if none
    bit m_out_v;
    int m_out_pc;
    bit m_err;
    bit m_halt;
    bit m_first;   // first edge after reset ignores redirect/stall

    task automatic model_reset();
        m_nxt    = RESET_PC_DEF;
        m_slot   = -1;
        m_out_v  = 1'b0;
        m_out_pc = 0;
        m_err    = 1'b0;
        m_halt   = 1'b0;
        m_first  = 1'b1;
    endtask

    task automatic model_edge(input bit stl, input bit rdv, input int rdpc);
        if (!m_first && rdv) begin
            m_out_v = 1'b0;
            m_slot  = -1;
            m_nxt   = rdpc;
            if (rdpc >= int'(DEPTH)) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
            end else begin
                m_halt = 1'b0;
            end
        end else if (!m_first && !m_halt && stl && m_out_v) begin
            // frozen: nothing moves
        end else begin
            m_out_v = (m_slot >= 0);
            if (m_slot >= 0) m_out_pc = m_slot;
            if (m_halt) begin
                m_slot = -1;
            end else begin
                m_slot = m_nxt;
                m_nxt++;
                if (m_nxt >= int'(DEPTH)) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                end
            end
        end
        m_first = 1'b0;
    endtask

    task automatic compare_all();
        check_eq("if_valid", 64'(if_valid), 64'(m_out_v));
        check_eq("addr_err", 64'(addr_err), 64'(m_err));
        check_eq("imem_pc", 64'(imem_pc), 64'(m_nxt));
        if (m_out_v) begin
            check_eq("if_pc", 64'(if_pc), 64'(m_out_pc));
            check_eq("if_inst", 64'(if_inst), 64'(mem[m_out_pc]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_if_valid"}, 64'(if_valid), 64'(0));
        check_eq({tag, "_if_pc"}, 64'(if_pc), 64'(0));
        check_eq({tag, "_if_inst"}, 64'(if_inst), 64'(0));
        check_eq({tag, "_addr_err"}, 64'(addr_err), 64'(0));
        check_eq({tag, "_imem_pc"}, 64'(imem_pc), 64'(RESET_PC_DEF));
    endtask

    // One clock: drive at negedge, model the edge, sample 1ns after it.
    task automatic step(input bit stl, input bit rdv, input int rdpc);
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = pc_t'(rdpc);
        @(posedge clk);
        model_edge(stl, rdv, rdpc);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch: if_pc 0 after the 2nd edge, then 1.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        // Stall three cycles holding if_pc=1, then continue 2,3,4,5.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
        // Redirect to 40 while if_pc=5.
        step(1'b0, 1'b1, 40);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
        // Redirect together with stall: flush wins.
        step(1'b1, 1'b1, 60);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        // Run off the end of memory, then recover with a redirect to 0.
        step(1'b0, 1'b1, 124);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
        // Out-of-range redirect halts immediately; in-range redirect resumes.
        step(1'b0, 1'b1, 200);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit s;
            bit r;
            int t;
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 99) < 4);
            t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(110, 135))
                                            : int'($urandom_range(0, 127));
            step(s, r, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
